// File: rtl/i2c_reg_responder_if.sv
// Two-wire bus pins seen by the i2c_reg_responder.
// The pad ties SDA's output to 0, so oSDA_OE=1 pulls the line low.
interface i2c_reg_responder_if;
   logic iSCL;
   logic iSDA;
   logic oSDA_OE;

   modport master (output iSCL, output iSDA, input oSDA_OE);
   modport slave  (input iSCL, input iSDA, output oSDA_OE);
endinterface

// File: rtl/i2c_reg_responder.sv
// I2C target: dev addr, sub-addr, data bytes into a REG_NUM x 8 register file.
// Define I2C_READ_EN to build the read-transfer path (R/W=1).
module i2c_reg_responder #(
   parameter logic [6:0] DEV_ADDR = 7'h1A,
   parameter int         REG_NUM  = 32,
   parameter int         FILT_LEN = 3,
   localparam int        AW       = $clog2(REG_NUM)
) (
   input  logic          iCLK,
   input  logic          iRST_N,
   i2c_reg_responder_if.slave bus,
   output logic          oWR_STB,
   output logic [AW-1:0] oWR_ADDR,
   output logic [7:0]    oWR_DATA,
   input  logic [AW-1:0] iRD_ADDR,
   output logic [7:0]    oRD_DATA,
   output logic          oBUSY
);

   localparam int CW = $clog2(FILT_LEN + 1);

   typedef enum logic [3:0] {
      IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WR, WR_ACK, WAIT
`ifdef I2C_READ_EN
      , RD, RD_ACK
`endif
   } state_t;

   state_t        state, stateN;
   logic [1:0]    sync1, sync2, filt;
   logic [CW-1:0] fcnt [2];
   logic          sclD, sdaD;
   logic          sclF, sdaF;
   logic          sclRise, sclFall, startDet, stopDet;
   logic [7:0]    regs [REG_NUM];
   logic [6:0]    shReg, shN;
   logic [3:0]    bitCnt, cntN;
   logic [AW-1:0] ptr, ptrN;
   logic          sdaOe, oeN;
   logic          busy, busyN;
   logic          ackPh, ackPhN;
   logic          we;
   logic [7:0]    byteIn;
`ifdef I2C_READ_EN
   logic          rdMode, rdModeN;
   logic [7:0]    rdByte;
`endif

   assign sclF     = filt[1];
   assign sdaF     = filt[0];
   assign sclRise  = sclF & ~sclD;
   assign sclFall  = ~sclF & sclD;
   assign startDet = sclF & sclD & sdaD & ~sdaF;
   assign stopDet  = sclF & sclD & ~sdaD & sdaF;
   assign byteIn   = {shReg, sdaF};
   assign oRD_DATA = regs[iRD_ADDR];
   assign oBUSY    = busy;
   assign bus.oSDA_OE = sdaOe;
`ifdef I2C_READ_EN
   assign rdByte   = regs[ptr];
`endif

   // Synchronize pads, then hold each level until FILT_LEN equal samples.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
         filt  <= 2'b11;
         sclD  <= 1'b1;
         sdaD  <= 1'b1;
         for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
         sync1 <= {bus.iSCL, bus.iSDA};
         sync2 <= sync1;
         sclD  <= filt[1];
         sdaD  <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == CW'(FILT_LEN - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + CW'(1);
            end
         end
      end
   end

   // State register.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) state <= IDLE;
      else         state <= stateN;
   end

   // Next state and next datapath values; START/STOP override any state.
   always_comb begin
      stateN = state;
      shN    = shReg;
      cntN   = bitCnt;
      ptrN   = ptr;
      oeN    = sdaOe;
      busyN  = busy;
      ackPhN = ackPh;
      we     = 1'b0;
`ifdef I2C_READ_EN
      rdModeN = rdMode;
`endif
      if (stopDet) begin
         stateN = IDLE;
         oeN    = 1'b0;
         busyN  = 1'b0;
         ackPhN = 1'b0;
      end else if (startDet) begin
         stateN = DEV;
         cntN   = 4'd0;
         oeN    = 1'b0;
         ackPhN = 1'b0;
      end else begin
         unique case (state)
            DEV, SUB, WR: begin
               if (sclRise) begin
                  shN  = byteIn[6:0];
                  cntN = bitCnt + 4'd1;
                  if (bitCnt == 4'd7) begin
                     cntN = 4'd0;
                     if (state == DEV) begin
                        stateN = WAIT;
                        if (byteIn[7:1] == DEV_ADDR && !byteIn[0]) begin
                           stateN = DEV_ACK;
                           busyN  = 1'b1;
`ifdef I2C_READ_EN
                           rdModeN = 1'b0;
                        end else if (byteIn[7:1] == DEV_ADDR) begin
                           stateN  = DEV_ACK;
                           busyN   = 1'b1;
                           rdModeN = 1'b1;
`endif
                        end
                     end else if (state == SUB) begin
                        stateN = WAIT;
                        if ({1'b0, byteIn} < 9'(REG_NUM)) begin
                           stateN = SUB_ACK;
                           ptrN   = byteIn[AW-1:0];
                        end
                     end else begin
                        stateN = WR_ACK;
                        we     = 1'b1;
                        ptrN   = ptr + AW'(1);
                     end
                  end
               end
            end
            DEV_ACK, SUB_ACK, WR_ACK: begin
               if (sclFall) begin
                  if (!ackPh) begin
                     oeN    = 1'b1;
                     ackPhN = 1'b1;
                  end else begin
                     oeN    = 1'b0;
                     ackPhN = 1'b0;
                     stateN = (state == DEV_ACK) ? SUB : WR;
`ifdef I2C_READ_EN
                     if (state == DEV_ACK && rdMode) begin
                        stateN = RD;
                        shN    = rdByte[6:0];
                        oeN    = ~rdByte[7];
                        cntN   = 4'd0;
                     end
`endif
                  end
               end
            end
`ifdef I2C_READ_EN
            RD: begin
               if (sclRise) begin
                  cntN = bitCnt + 4'd1;
               end else if (sclFall) begin
                  if (bitCnt == 4'd8) begin
                     oeN    = 1'b0;
                     cntN   = 4'd0;
                     stateN = RD_ACK;
                  end else begin
                     oeN = ~shReg[6];
                     shN = {shReg[5:0], 1'b0};
                  end
               end
            end
            RD_ACK: begin
               if (sclRise) begin
                  if (sdaF) begin
                     stateN = WAIT;
                  end else begin
                     ackPhN = 1'b1;
                     ptrN   = ptr + AW'(1);
                  end
               end else if (sclFall && ackPh) begin
                  ackPhN = 1'b0;
                  stateN = RD;
                  shN    = rdByte[6:0];
                  oeN    = ~rdByte[7];
                  cntN   = 4'd0;
               end
            end
`endif
            IDLE, WAIT: begin
               stateN = state;
            end
            default: stateN = IDLE;
         endcase
      end
   end

   // Datapath registers follow the values chosen above.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         shReg  <= '0;
         bitCnt <= '0;
         ptr    <= '0;
         sdaOe  <= 1'b0;
         busy   <= 1'b0;
         ackPh  <= 1'b0;
`ifdef I2C_READ_EN
         rdMode <= 1'b0;
`endif
      end else begin
         shReg  <= shN;
         bitCnt <= cntN;
         ptr    <= ptrN;
         sdaOe  <= oeN;
         busy   <= busyN;
         ackPh  <= ackPhN;
`ifdef I2C_READ_EN
         rdMode <= rdModeN;
`endif
      end
   end

   // Register file write and the matching one-cycle strobe.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
         oWR_STB  <= 1'b0;
         oWR_ADDR <= '0;
         oWR_DATA <= '0;
      end else begin
         oWR_STB <= we;
         if (we) begin
            regs[ptr] <= byteIn;
            oWR_ADDR  <= ptr;
            oWR_DATA  <= byteIn;
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Bench for i2c_reg_responder: bit-banged master, write scoreboard.
// Build with +define+I2C_READ_EN to exercise the read path.
`timescale 1ns/1ps
module tb_i2c_reg_responder;

   localparam int Q = 10;

   typedef struct {
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       sclDrv = 1'b1;
   logic       sdaDrv = 1'b1;
   logic       wrStb;
   logic [4:0] wrAddr;
   logic [7:0] wrData;
   logic [4:0] rdAddr = 5'd5;
   logic [7:0] rdData;
   logic       busy;
   int         total = 0;
   int         bad = 0;
   int         oeCnt = 0;
   int         busyCnt = 0;
   logic       stbPrev = 1'b0;
   wr_t        sb [$];

   i2c_reg_responder_if bus();

   assign bus.iSCL = sclDrv;
   assign bus.iSDA = sdaDrv & ~bus.oSDA_OE;

   i2c_reg_responder dut (
      .iCLK     (clk),
      .iRST_N   (rstN),
      .bus      (bus.slave),
      .oWR_STB  (wrStb),
      .oWR_ADDR (wrAddr),
      .oWR_DATA (wrData),
      .iRD_ADDR (rdAddr),
      .oRD_DATA (rdData),
      .oBUSY    (busy)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.oSDA_OE) oeCnt++;
      if (busy) busyCnt++;
      if (wrStb) begin
         chk("stbWidth", 32'(stbPrev), 32'd0);
         chk("stbExpected", 32'(wrStb), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            wr_t e;
            e = sb.pop_front();
            chk("wrAddr", 32'(wrAddr), 32'(e.a));
            chk("wrData", 32'(wrData), 32'(e.d));
         end
      end
      stbPrev <= wrStb;
   end

   task automatic qw();
      repeat (Q) @(posedge clk);
   endtask

   task automatic start();
      sdaDrv = 1'b1; qw();
      sclDrv = 1'b1; qw();
      sdaDrv = 1'b0; qw();
      sclDrv = 1'b0; qw();
   endtask

   task automatic stop();
      sdaDrv = 1'b0; qw();
      sclDrv = 1'b1; qw();
      sdaDrv = 1'b1; qw();
   endtask

   task automatic sendBits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sdaDrv = b[i]; qw();
         sclDrv = 1'b1; qw(); qw();
         sclDrv = 1'b0; qw();
      end
   endtask

   task automatic writeByte(input logic [7:0] b, output logic ack);
      sendBits(b);
      sdaDrv = 1'b1; qw();
      sclDrv = 1'b1; qw();
      ack = bus.iSDA;
      qw();
      sclDrv = 1'b0; qw();
   endtask

   task automatic readByte(output logic [7:0] b, input logic ackBit);
      sdaDrv = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         qw();
         sclDrv = 1'b1; qw();
         b[i] = bus.iSDA;
         qw();
         sclDrv = 1'b0;
      end
      qw();
      sdaDrv = ackBit; qw();
      sclDrv = 1'b1; qw(); qw();
      sclDrv = 1'b0; qw();
      sdaDrv = 1'b1;
   endtask

   task automatic pushWr(input logic [4:0] a, input logic [7:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic readReg(input string tag, input logic [4:0] a,
                          input logic [7:0] d);
      rdAddr = a;
      @(negedge clk);
      chk(tag, 32'(rdData), 32'(d));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic       ack;
      logic [7:0] rb;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rstOe", 32'(bus.oSDA_OE), 32'd0);
      chk("rstStb", 32'(wrStb), 32'd0);
      chk("rstAddr", 32'(wrAddr), 32'd0);
      chk("rstData", 32'(wrData), 32'd0);
      chk("rstBusy", 32'(busy), 32'd0);
      chk("rstRd", 32'(rdData), 32'd0);
      rstN = 1'b1;
      qw();

      start();
      writeByte(8'h34, ack); chk("t1DevAck", 32'(ack), 32'd0);
      chk("t1Busy", 32'(busy), 32'd1);
      writeByte(8'h05, ack); chk("t1SubAck", 32'(ack), 32'd0);
      pushWr(5'd5, 8'hA7);
      writeByte(8'hA7, ack); chk("t1DatAck", 32'(ack), 32'd0);
      stop(); qw();
      chk("t1BusyOff", 32'(busy), 32'd0);
      readReg("t1Reg5", 5'd5, 8'hA7);
      chk("t1Sb", 32'(sb.size()), 32'd0);

      start();
      writeByte(8'h34, ack); chk("t2DevAck", 32'(ack), 32'd0);
      writeByte(8'h1F, ack); chk("t2SubAck", 32'(ack), 32'd0);
      pushWr(5'd31, 8'h11);
      writeByte(8'h11, ack); chk("t2Ack0", 32'(ack), 32'd0);
      pushWr(5'd0, 8'h22);
      writeByte(8'h22, ack); chk("t2Ack1", 32'(ack), 32'd0);
      stop(); qw();
      readReg("t2Reg31", 5'd31, 8'h11);
      readReg("t2Reg0", 5'd0, 8'h22);
      chk("t2Sb", 32'(sb.size()), 32'd0);

      oeCnt = 0;
      busyCnt = 0;
      start();
      writeByte(8'h40, ack); chk("t3DevNack", 32'(ack), 32'd1);
      writeByte(8'hA5, ack); chk("t3Nack1", 32'(ack), 32'd1);
      writeByte(8'h5A, ack); chk("t3Nack2", 32'(ack), 32'd1);
      stop(); qw();
      chk("t3OeNever", 32'(oeCnt), 32'd0);
      chk("t3BusyNever", 32'(busyCnt), 32'd0);

      start();
      writeByte(8'h34, ack); chk("t4DevAck", 32'(ack), 32'd0);
      writeByte(8'h20, ack); chk("t4SubNack", 32'(ack), 32'd1);
      writeByte(8'h99, ack); chk("t4DatNack", 32'(ack), 32'd1);
      stop(); qw();
      readReg("t4Reg0", 5'd0, 8'h22);
      readReg("t4Reg5", 5'd5, 8'hA7);
      readReg("t4Reg31", 5'd31, 8'h11);

      @(posedge clk);
      sdaDrv = 1'b0;
      repeat (2) @(posedge clk);
      sdaDrv = 1'b1;
      qw();
      sclDrv = 1'b0; qw();
      writeByte(8'h34, ack); chk("t5NoStart", 32'(ack), 32'd1);
      chk("t5Busy", 32'(busy), 32'd0);
      stop(); qw();

`ifdef I2C_READ_EN
      start();
      writeByte(8'h34, ack);
      writeByte(8'h06, ack);
      pushWr(5'd6, 8'h5C);
      writeByte(8'h5C, ack); chk("t6WrAck", 32'(ack), 32'd0);
      stop(); qw();
      start();
      writeByte(8'h34, ack);
      writeByte(8'h05, ack); chk("t6SubAck", 32'(ack), 32'd0);
      start();
      writeByte(8'h35, ack); chk("t6RdAck", 32'(ack), 32'd0);
      readByte(rb, 1'b0); chk("t6Rd0", 32'(rb), 32'hA7);
      readByte(rb, 1'b1); chk("t6Rd1", 32'(rb), 32'h5C);
      chk("t6Release", 32'(bus.oSDA_OE), 32'd0);
      stop(); qw();
`else
      start();
      writeByte(8'h34, ack);
      writeByte(8'h05, ack); chk("t6SubAck", 32'(ack), 32'd0);
      start();
      writeByte(8'h35, ack); chk("t6RdNack", 32'(ack), 32'd1);
      rb = 8'h00;
      stop(); qw();
      chk("t6Oe", 32'(bus.oSDA_OE) | 32'(rb), 32'd0);
`endif
      chk("sbEmpty", 32'(sb.size()), 32'd0);

      start();
      sendBits(8'h34);
      sdaDrv = 1'b1; qw();
      chk("t7OeOn", 32'(bus.oSDA_OE), 32'd1);
      @(posedge clk);
      #2 rstN = 1'b0;
      #1 chk("t7OeAsync", 32'(bus.oSDA_OE), 32'd0);
      sclDrv = 1'b1;
      sdaDrv = 1'b1;
      @(negedge clk);
      chk("t7Busy", 32'(busy), 32'd0);
      readReg("t7Reg5", 5'd5, 8'h00);
      readReg("t7Reg31", 5'd31, 8'h00);
      rstN = 1'b1;
      qw();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_reg_responder.md
# i2c_reg_responder

I2C target (responder) that answers the same write framing our configuration masters emit: device address, 8-bit sub-address, data bytes. It oversamples SCL/SDA on the system clock and holds a 32 × 8 register file that synth-side logic reads. Each accepted byte also produces a write strobe. It lets an external controller, or a bench-side master model, program synth parameters over the same two-wire bus used for codec setup.

## Interface

- DEV_ADDR, 7'h1A, 7-bit device address answered (8'h34 write byte).
- REG_NUM, 32, register count; legal sub-addresses 0..REG_NUM-1; power of two, ≤ 256.
- FILT_LEN, 3, glitch filter depth in iCLK cycles.
- iCLK input 1: system clock (50 MHz); must be ≥ 20 × SCL rate.
- iRST_N input 1: asynchronous, active-low reset.
- iSCL input 1: bus clock (pad input).
- iSDA input 1: bus data (pad input).
- oSDA_OE output 1: 1 = drive SDA low; 0 = release. The pad ties the output to 0.
- oWR_STB output 1: one-cycle pulse per accepted data byte.
- oWR_ADDR output 5: register index of the write (log2 REG_NUM bits).
- oWR_DATA output 8: data of the write.
- iRD_ADDR input 5: host-side read index.
- oRD_DATA output 8: register[iRD_ADDR], combinational.
- oBUSY output 1: high from an addressed START (our address matched) until STOP.

## Operation

- Input path: 2-flop synchronizer, then the glitch filter. The filtered level changes only after FILT_LEN consecutive identical samples. Edge detection runs on the filtered levels.
- START = SDA falls while SCL is high. STOP = SDA rises while SCL is high. Either one is recognized in any state, including mid-byte.
- Bits are sampled on the filtered SCL rise, MSB first. oSDA_OE changes only on the filtered SCL fall.
- States:
  - IDLE
  - DEV: shift 8 bits
  - DEV_ACK
  - SUB: shift 8 bits
  - SUB_ACK
  - WR: shift 8 bits
  - WR_ACK
  - RD: drive 8 bits
  - RD_ACK: sample master ACK
  - WAIT: ignore bus until START/STOP
- Transitions:
  - START → DEV.
  - DEV: 7-bit match and R/W=0 → DEV_ACK → SUB. Mismatch → WAIT, SDA never driven.
  - SUB: byte < REG_NUM → ptr = byte, SUB_ACK → WR. Byte ≥ REG_NUM → NACK (SDA released), → WAIT.
  - WR: on 8th bit, register[ptr] is written and oWR_STB pulses with oWR_ADDR = ptr and oWR_DATA = byte. Then WR_ACK, ptr increments, → WR.
  - Repeated START → DEV; ptr is kept. STOP → IDLE.
- Pointer wraps from REG_NUM-1 to 0.
- ACK drive: oSDA_OE is set on the SCL fall after bit 8 and cleared on the following SCL fall.
- Reset: all registers 0, ptr 0, state IDLE. An asserted reset mid-byte releases SDA immediately (asynchronous).
- A host read of the index being written in the same cycle returns the old value. The new value is visible the next cycle.

## Timing

- Reset values:
  - oSDA_OE 0
  - oWR_STB 0
  - oWR_ADDR 0
  - oWR_DATA 0
  - oBUSY 0
  - oRD_DATA = register[iRD_ADDR] = 0
- Pin-to-filtered latency: 2 + FILT_LEN iCLK cycles.
- oWR_STB: asserted 1 iCLK after the filtered SCL rise of data bit 0 (the 8th bit); width exactly 1 cycle.
- oSDA_OE: updates 1 iCLK after the filtered SCL fall.
- oBUSY: rises 1 iCLK after the SCL rise of the address byte's 8th bit (on a match). Falls 1 iCLK after STOP is detected.
- Glitches shorter than FILT_LEN cycles on either line produce no edge, no START/STOP and no state change.

## Configuration

- I2C_READ_EN defined: read transfers are supported.
  - Address match with R/W=1 → ACK → RD.
  - RD drives register[ptr] MSB first: oSDA_OE = ~bit, changed on SCL falls.
  - RD_ACK samples the master bit. ACK → ptr++, next byte. NACK → release SDA, → WAIT.
- I2C_READ_EN undefined: R/W=1 with a matching address is NACKed → WAIT. The read logic is not built.

## Test plan

- Write 8'h34, 8'h05, 8'hA7, STOP → three ACKs; oWR_STB pulses once with addr 5, data A7; oRD_DATA at iRD_ADDR=5 is A7; oBUSY low after STOP.
- Burst write 8'h34, 8'h1F, 8'h11, 8'h22 → writes reg31=11 and reg0=22 (wrap); two strobes.
- Address 8'h40 (mismatch) followed by data bytes → oSDA_OE never asserts; no strobe; oBUSY stays 0.
- Sub-address 8'h20 → NACK on sub-address; subsequent data ignored; registers unchanged.
- 2-cycle SDA low pulse while SCL high → no START detected. iRST_N asserted mid-byte → oSDA_OE=0 same cycle, registers 0.
- I2C_READ_EN build: write ptr 8'h05, then Sr, 8'h35 → bytes A7 then reg6 are returned; master NACK → SDA released. Without the macro, 8'h35 is NACKed.
